// File: rtl/status_reg.sv
// 6502 processor status register (P).
// Holds the six real flags N, V, D, I, Z, C. Bit 5 always reads 1 and bit 4
// (B) exists only in the pushed image. Flag sources, lowest to highest
// precedence: ALU write enables, flag instructions, interrupt entry (I only),
// load from the data bus (PLP/RTI). Reset overrides everything.
//
// Handshake: there is no valid/ready flow control here. Each enable input
// (flag_we bits, flag_op_valid, irq_entry, p_load) is a single-cycle strobe
// sampled on the rising edge of clk. The block never stalls, so every strobe
// that is high at an edge is consumed at that edge.
module status_reg #(
  parameter logic [7:0] RESET_P        = 8'h24,
  parameter int         IRQ_MASK_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_flags,
  input  logic [7:0] flag_we,
  input  logic       flag_op_valid,
  input  logic [2:0] flag_op,
  input  logic       p_load,
  input  logic [7:0] data_in,
  input  logic       irq_entry,
  input  logic       push_brk,
  output logic [7:0] p_out,
  output logic [7:0] p_push,
  output logic       carry_q,
  output logic       decimal_mode,
  output logic       irq_mask
);

  // Flag instruction encodings
  localparam logic [2:0] OP_SEC = 3'd0;
  localparam logic [2:0] OP_CLC = 3'd1;
  localparam logic [2:0] OP_SEI = 3'd2;
  localparam logic [2:0] OP_CLI = 3'd3;
  localparam logic [2:0] OP_SED = 3'd4;
  localparam logic [2:0] OP_CLD = 3'd5;
  localparam logic [2:0] OP_CLV = 3'd6;

  // Stored flags
  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;

  // High when interrupt entry is the source of I at this edge; the IRQ mask
  // follows such a set immediately rather than with the usual lag.
  logic i_forced;

  // Bits 5:4 of the flag buses carry no stored state.
  logic unused_bits;
  assign unused_bits = ^{alu_flags[5:4], flag_we[5:4], data_in[5:4]};

  // Next-state flags, built up from the lowest precedence source to the highest
  always_comb begin
    n_d      = n_q;
    v_d      = v_q;
    d_d      = d_q;
    i_d      = i_q;
    z_d      = z_q;
    c_d      = c_q;
    i_forced = 1'b0;

    if (flag_we[7]) n_d = alu_flags[7];
    if (flag_we[6]) v_d = alu_flags[6];
    if (flag_we[3]) d_d = alu_flags[3];
    if (flag_we[2]) i_d = alu_flags[2];
    if (flag_we[1]) z_d = alu_flags[1];
    if (flag_we[0]) c_d = alu_flags[0];

    if (flag_op_valid) begin
      case (flag_op)
        OP_SEC:  c_d = 1'b1;
        OP_CLC:  c_d = 1'b0;
        OP_SEI:  i_d = 1'b1;
        OP_CLI:  i_d = 1'b0;
        OP_SED:  d_d = 1'b1;
        OP_CLD:  d_d = 1'b0;
        OP_CLV:  v_d = 1'b0;
        default: ; // reserved encoding is a no-op
      endcase
    end

    if (irq_entry) begin
      i_d      = 1'b1;
      i_forced = 1'b1;
    end

    if (p_load) begin
      n_d      = data_in[7];
      v_d      = data_in[6];
      d_d      = data_in[3];
      i_d      = data_in[2];
      z_d      = data_in[1];
      c_d      = data_in[0];
      i_forced = 1'b0;
    end
  end

  // Flag register with asynchronous reset to RESET_P
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q <= RESET_P[7];
      v_q <= RESET_P[6];
      d_q <= RESET_P[3];
      i_q <= RESET_P[2];
      z_q <= RESET_P[1];
      c_q <= RESET_P[0];
    end else begin
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  assign p_out        = {n_q, v_q, 1'b1, 1'b0,     d_q, i_q, z_q, c_q};
  assign p_push       = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
  assign carry_q      = c_q;
  assign decimal_mode = d_q;

  generate
    if (IRQ_MASK_DELAY == 0) begin : g_mask_direct
      assign irq_mask = i_q;
    end else begin : g_mask_delay
      logic mask_q;

      // Mask trails I by one cycle, except that an interrupt-entry set is
      // taken at once. Because the mask still holds the old I on the cycle
      // after CLI, an interrupt entry on that cycle keeps the mask high.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mask_q <= RESET_P[2];
        end else if (i_forced) begin
          mask_q <= 1'b1;
        end else begin
          mask_q <= i_q;
        end
      end

      assign irq_mask = mask_q;
    end
  endgenerate

endmodule

// File: tb/tb_status_reg.sv
module tb_status_reg;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_flags, flag_we, data_in;
  logic       flag_op_valid, p_load, irq_entry, push_brk;
  logic [2:0] flag_op;
  logic [7:0] p_out, p_push;
  logic       carry_q, decimal_mode, irq_mask;

  always #5 clk = ~clk;

  status_reg #(.RESET_P(8'h24), .IRQ_MASK_DELAY(1)) dut (
    .clk(clk), .reset(reset), .alu_flags(alu_flags), .flag_we(flag_we),
    .flag_op_valid(flag_op_valid), .flag_op(flag_op), .p_load(p_load),
    .data_in(data_in), .irq_entry(irq_entry), .push_brk(push_brk),
    .p_out(p_out), .p_push(p_push), .carry_q(carry_q),
    .decimal_mode(decimal_mode), .irq_mask(irq_mask)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    alu_flags = 8'h00; flag_we = 8'h00; flag_op_valid = 1'b0; flag_op = 3'd0;
    p_load = 1'b0; data_in = 8'h00; irq_entry = 1'b0;
  endtask

  // Wait one active edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] we;
    logic [7:0] alu;
    logic       opv;
    logic [2:0] op;
    logic       ld;
    logic [7:0] din;
    logic       ie;
    logic [7:0] exp_p;
    logic       exp_m;
  } vec_t;

  function automatic vec_t mk(logic [7:0] we, logic [7:0] alu, logic opv, logic [2:0] op,
                              logic ld, logic [7:0] din, logic ie,
                              logic [7:0] exp_p, logic exp_m);
    vec_t v;
    v.we = we; v.alu = alu; v.opv = opv; v.op = op; v.ld = ld; v.din = din;
    v.ie = ie; v.exp_p = exp_p; v.exp_m = exp_m;
    return v;
  endfunction

  vec_t vecs[23];

  // ---------------- reference model ----------------
  // P kept as a plain byte; each source is applied in ascending precedence.
  logic [7:0] m_p;
  logic       m_mask;
  logic [8:0] exp_q[$];

  int op_bit[7] = '{0, 0, 2, 2, 3, 3, 6};
  logic op_val[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic model_step(input logic [7:0] we, input logic [7:0] alu, input logic opv,
                            input logic [2:0] op, input logic ld, input logic [7:0] din,
                            input logic ie);
    logic [7:0] nxt;
    logic       prev_i;
    int         stored[6] = '{7, 6, 3, 2, 1, 0};
    nxt    = m_p;
    prev_i = m_p[2];
    foreach (stored[k]) if (we[stored[k]]) nxt[stored[k]] = alu[stored[k]];
    if (opv && op != 3'd7) nxt[op_bit[op]] = op_val[op];
    if (ie) nxt[2] = 1'b1;
    if (ld) nxt = din;
    nxt[5] = 1'b1;
    nxt[4] = 1'b0;
    m_mask = (ie && !ld) ? 1'b1 : prev_i;
    m_p    = nxt;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [8:0] e;
    logic [7:0] r_we, r_alu, r_din;
    logic       r_opv, r_ld, r_ie;
    logic [2:0] r_op;

    vecs[0]  = mk(8'hC3, 8'hC3, 0, 3'd0, 0, 8'h00, 0, 8'hE7, 1);
    vecs[1]  = mk(8'h00, 8'h00, 1, 3'd1, 0, 8'h00, 0, 8'hE6, 1); // CLC
    vecs[2]  = mk(8'h00, 8'h00, 1, 3'd3, 0, 8'h00, 0, 8'hE2, 1); // CLI
    vecs[3]  = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 1, 8'hE6, 1); // irq right after CLI
    vecs[4]  = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 8'hE6, 1);
    vecs[5]  = mk(8'h00, 8'h00, 1, 3'd3, 0, 8'h00, 0, 8'hE2, 1); // CLI
    vecs[6]  = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 8'hE2, 0); // mask falls late
    vecs[7]  = mk(8'h00, 8'h00, 1, 3'd2, 0, 8'h00, 0, 8'hE6, 0); // SEI
    vecs[8]  = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 8'hE6, 1); // mask rises late
    vecs[9]  = mk(8'hFF, 8'h00, 1, 3'd0, 1, 8'hDB, 0, 8'hEB, 1); // PLP beats SEC/we
    vecs[10] = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 8'hEB, 0);
    vecs[11] = mk(8'h00, 8'h00, 1, 3'd5, 0, 8'h00, 0, 8'hE3, 0); // CLD
    vecs[12] = mk(8'h08, 8'h00, 1, 3'd4, 0, 8'h00, 0, 8'hEB, 0); // SED beats we D=0
    vecs[13] = mk(8'h01, 8'h00, 1, 3'd5, 0, 8'h00, 0, 8'hE2, 0); // CLD + we C=0
    vecs[14] = mk(8'h01, 8'h01, 1, 3'd4, 0, 8'h00, 0, 8'hEB, 0); // SED + we C=1
    vecs[15] = mk(8'h00, 8'h00, 1, 3'd7, 0, 8'h00, 0, 8'hEB, 0); // reserved op
    vecs[16] = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 8'hEB, 0); // op invalid
    vecs[17] = mk(8'h00, 8'h00, 1, 3'd3, 0, 8'h00, 1, 8'hEF, 1); // irq beats CLI
    vecs[18] = mk(8'h00, 8'h00, 0, 3'd0, 1, 8'h00, 0, 8'h20, 1); // PLP clears I
    vecs[19] = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 8'h20, 0);
    vecs[20] = mk(8'h00, 8'h00, 0, 3'd0, 1, 8'h00, 1, 8'h20, 0); // PLP beats irq
    vecs[21] = mk(8'hFF, 8'hFF, 0, 3'd0, 0, 8'h00, 0, 8'hEF, 0); // bit4 write ignored
    vecs[22] = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 8'hEF, 1);

    // Reset and power-on values
    reset = 1'b1;
    push_brk = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_p_out", p_out, 8'h24);
    check("rst_mask", {7'd0, irq_mask}, 8'h01);
    check("rst_push_brk1", p_push, 8'h34);
    push_brk = 1'b0;
    #1;
    check("rst_push_brk0", p_push, 8'h24);

    // Table-driven vectors
    for (int i = 0; i < 23; i++) begin
      alu_flags = vecs[i].alu; flag_we = vecs[i].we;
      flag_op_valid = vecs[i].opv; flag_op = vecs[i].op;
      p_load = vecs[i].ld; data_in = vecs[i].din; irq_entry = vecs[i].ie;
      push_brk = i[0];
      step();
      check($sformatf("vec%0d_p_out", i), p_out, vecs[i].exp_p);
      check($sformatf("vec%0d_mask", i), {7'd0, irq_mask}, {7'd0, vecs[i].exp_m});
      check($sformatf("vec%0d_push", i), p_push, vecs[i].exp_p | {3'b000, i[0], 4'b0000});
      check($sformatf("vec%0d_carry", i), {7'd0, carry_q}, {7'd0, vecs[i].exp_p[0]});
      check($sformatf("vec%0d_dec", i), {7'd0, decimal_mode}, {7'd0, vecs[i].exp_p[3]});
    end
    drive_idle();

    // Mid-cycle asynchronous reset from a non-reset state (P=EF, mask=1)
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_p_out", p_out, 8'h24);
    check("async_rst_mask", {7'd0, irq_mask}, 8'h01);
    check("async_rst_carry", {7'd0, carry_q}, 8'h00);
    push_brk = 1'b1;
    #1;
    check("async_rst_push1", p_push, 8'h34);

    // Update attempted while reset is held is discarded
    flag_we = 8'hFF; alu_flags = 8'hFF; flag_op_valid = 1'b1; flag_op = 3'd0;
    step();
    check("rst_hold_p_out", p_out, 8'h24);
    check("rst_hold_mask", {7'd0, irq_mask}, 8'h01);
    reset = 1'b0;
    drive_idle();
    m_p = 8'h24;
    m_mask = 1'b1;

    // Randomized stimulus against the reference model
    for (int i = 0; i < 400; i++) begin
      r_we  = 8'($urandom_range(0, 255));
      r_alu = 8'($urandom_range(0, 255));
      r_opv = ($urandom_range(0, 1) == 1);
      r_op  = 3'($urandom_range(0, 7));
      r_ld  = ($urandom_range(0, 7) == 0);
      r_din = 8'($urandom_range(0, 255));
      r_ie  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) r_we = 8'h00;
      alu_flags = r_alu; flag_we = r_we; flag_op_valid = r_opv; flag_op = r_op;
      p_load = r_ld; data_in = r_din; irq_entry = r_ie;
      push_brk = ($urandom_range(0, 1) == 1);
      model_step(r_we, r_alu, r_opv, r_op, r_ld, r_din, r_ie);
      exp_q.push_back({m_mask, m_p});
      step();
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_p_out", i), p_out, e[7:0]);
      check($sformatf("rnd%0d_mask", i), {7'd0, irq_mask}, {7'd0, e[8]});
      check($sformatf("rnd%0d_push", i), p_push, e[7:0] | {3'b000, push_brk, 4'b0000});
    end
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/status_reg.md
Name: status_reg

Overview:
- Processor status register (P) of the 6502 core, directly downstream of the ALU.
- Captures the ALU flag vector under per-bit write enables and executes the flag instructions SEC/CLC/SEI/CLI/SED/CLD/CLV.
- Loads P from the data bus for PLP/RTI, sets I on interrupt entry, and supplies the pushed P image for PHP/BRK/IRQ/NMI.
- Drives the registered carry back into the ALU, the decimal-mode flag, and the IRQ mask to the interrupt logic.

Parameters:
RESET_P, 8'h24, P value after reset (I=1, bit5=1, all other flags 0).
IRQ_MASK_DELAY, 1, cycles by which irq_mask lags I for CLI/SEI/PLP (legal values 0 or 1).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
alu_flags  input  8  ALU flag vector; bit map N=7, V=6, B=4, D=3, I=2, Z=1, C=0.
flag_we  input  8  per-bit write enable for alu_flags; bits 5 and 4 ignored.
flag_op_valid  input  1  execute flag_op this cycle.
flag_op  input  3  0 SEC, 1 CLC, 2 SEI, 3 CLI, 4 SED, 5 CLD, 6 CLV, 7 reserved (no-op).
p_load  input  1  load P from data_in (PLP/RTI).
data_in  input  8  pulled status byte.
irq_entry  input  1  interrupt/BRK entry; sets I.
push_brk  input  1  selects the B value in p_push (1 for PHP/BRK, 0 for IRQ/NMI).
p_out  output  8  current P; bit5 reads 1, bit4 reads 0.
p_push  output  8  P image for stack push; bit5=1, bit4=push_brk.
carry_q  output  1  registered C, feeds ALU carry_in.
decimal_mode  output  1  registered D.
irq_mask  output  1  IRQ inhibit seen by interrupt logic.

Behaviour:
- Storage is six flops: N, V, D, I, Z, C. Bits 5 and 4 are not stored.
- Reset (asynchronous): stored flags take RESET_P bits 7,6,3,2,1,0, so p_out=8'h24, carry_q=0, decimal_mode=0, irq_mask=1. Reset during any update discards that update.
- All updates are visible on p_out one cycle after the enabling edge. There is no combinational path from inputs to p_out.
- p_push is combinational from stored P and push_brk; zero latency relative to p_out.
- Priority per bit, highest first: reset > p_load > irq_entry (I only) > flag_op > flag_we.
- p_load: all six bits take data_in[7,6,3,2,1,0]. data_in[5:4] is ignored. Any simultaneous flag_op, flag_we or irq_entry is discarded.
- irq_entry: sets I=1. Other bits may update in the same cycle from flag_op/flag_we.
- flag_op: affects only its target bit. flag_we on other bits in the same cycle also applies.
- flag_op 7 and flag_op_valid=0 are no-ops.
- flag_we: each enabled bit in {7,6,3,2,1,0} takes alu_flags of the same index. Disabled bits hold.
- irq_mask, IRQ_MASK_DELAY=1:
  - I changes caused by SEI, CLI or p_load reach irq_mask one cycle after they reach p_out[2].
  - I set by irq_entry or reset reaches irq_mask in the same cycle as p_out[2] (no delay).
  - If irq_entry follows CLI by one cycle, irq_mask stays 1 throughout.
- irq_mask, IRQ_MASK_DELAY=0: irq_mask equals p_out[2] at all times.
- carry_q = p_out[0]; decimal_mode = p_out[3].

Test Plan:
- Assert reset mid-cycle, then release -> p_out=8'h24, irq_mask=1, carry_q=0 asynchronously; p_push=8'h34 with push_brk=1, 8'h24 with push_brk=0.
- alu_flags=8'hC3, flag_we=8'hC3 -> next cycle p_out=8'hE7 (N,V,I,Z,C set, bit5=1); then flag_op CLC alone -> p_out=8'hE6, carry_q=0.
- CLI issued -> p_out[2]=0 after one cycle, irq_mask falls one cycle later; next cycle irq_entry=1 -> p_out[2]=1 and irq_mask=1 the same cycle, irq_mask never observed low.
- p_load with data_in=8'hDB together with flag_op SEC and flag_we=8'hFF, alu_flags=8'h00 -> p_out=8'hEB (bit4 dropped, bit5 forced); flag_op and flag_we discarded.
- flag_op SED with flag_we=8'h08, alu_flags=8'h00 in the same cycle -> decimal_mode=1 (flag_op wins); with flag_we=8'h01, alu_flags=8'h01 -> D=1 and C=1 both applied.
- flag_op=7 with flag_op_valid=1, then flag_op_valid=0 with flag_op=0 -> p_out unchanged across both cycles.
